// File: rtl/cache_pkg.sv
// cache_pkg: shared opcode constants, block width and the miss-sequencer
// state encoding used by the data cache and its controller.
package cache_pkg;

    // Width of one cache block (two 32-bit words), shared with cache and data memory
    localparam int BLOCK_WIDTH = 64;

    // Memory-stage opcodes that access the data cache
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Miss-handling sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } ctrl_state_t;

    // True when the opcode is a load or a store
    function automatic logic is_mem_op(input logic [6:0] op_i);
        return (op_i == OP_LOAD) || (op_i == OP_STORE);
    endfunction

endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// sat_counter: 32-bit up-counter that sticks at all-ones instead of wrapping.
// Synchronous active-high reset, increments by one when inc is high.
module sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Next count: add one unless disabled or already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: miss-handling sequencer for the 2-way data cache.
// Detects load/store misses, stalls the pipeline, fetches the 64-bit block
// over a req/ack handshake and pulses the cache fill enable for one cycle.
// Optional feature macro: CACHE_PERF_CNT_EN adds saturating access and miss
// counters (access_count, miss_count ports).
module cache_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WIDTH = cache_pkg::BLOCK_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             op,
    input  logic [DATA_WIDTH-1:0]  a,
    input  logic                   hit,
    output logic                   cpu_stall,
    output logic                   refill,
    output logic [BLOCK_WIDTH-1:0] block_rd,
    output logic                   mem_req,
    output logic [DATA_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [BLOCK_WIDTH-1:0] mem_rdata
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]            access_count,
    output logic [31:0]            miss_count
`endif
);

    import cache_pkg::*;

    ctrl_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0]  a_lat_q, a_lat_d;
    logic [BLOCK_WIDTH-1:0] block_rd_q, block_rd_d;

    logic access_s;
    logic stall_s;
    logic mem_req_s;
    logic refill_s;
    logic unused_lat_bits_s;

    assign access_s = is_mem_op(op);

    // Next-state, address/block capture and per-state output decode
    always_comb begin
        state_d    = state_q;
        a_lat_d    = a_lat_q;
        block_rd_d = block_rd_q;
        stall_s    = 1'b0;
        mem_req_s  = 1'b0;
        refill_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_s && !hit) begin
                    stall_s = 1'b1;
                    a_lat_d = a;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                mem_req_s = 1'b1;
                stall_s   = 1'b1;
                if (mem_ack) begin
                    block_rd_d = mem_rdata;
                    state_d    = FILL;
                end else begin
                    state_d = REQ;
                end
            end
            FILL: begin
                refill_s = 1'b1;
                stall_s  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched address and fetched block registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_lat_q    <= '0;
            block_rd_q <= '0;
        end else begin
            state_q    <= state_d;
            a_lat_q    <= a_lat_d;
            block_rd_q <= block_rd_d;
        end
    end

    // Stall is suppressed while reset is held so the pipeline can be flushed
    assign cpu_stall = stall_s & ~rst;
    assign mem_req   = mem_req_s;
    assign refill    = refill_s;
    assign block_rd  = block_rd_q;
    assign mem_addr  = {a_lat_q[DATA_WIDTH-1:3], 3'b000};

    // Low address bits select a word inside the block; the fetch ignores them
    assign unused_lat_bits_s = ^a_lat_q[2:0];

`ifdef CACHE_PERF_CNT_EN
    logic acc_inc_s;
    logic miss_inc_s;

    assign acc_inc_s  = (state_q == IDLE) && access_s && hit;
    assign miss_inc_s = (state_q == IDLE) && access_s && !hit;

    sat_counter u_access_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (acc_inc_s),
        .count (access_count)
    );

    sat_counter u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc_s),
        .count (miss_count)
    );
`endif

endmodule
